// File: rtl/button_event_arbiter.sv
// button_event_arbiter
// Turns presses on N_BUTTONS asynchronous push-buttons into one stream of
// events with a valid/ready handshake. Each button has a 3-flop synchroniser
// and a rising-edge detector. Pending presses are granted round-robin.
// A press that arrives while the same button is still pending is dropped and
// counted.
//
// Optional feature macro: BUTTON_LOCKOUT_EN
//   When defined, each button gets a lockout (debounce) counter that is
//   LOCKOUT_CYCLES long. When not defined, every edge is qualified and
//   LOCKOUT_CYCLES is used only by the parameter range check.
//
// Ports:
//   clk        system clock, all flops on rising edge
//   rst        asynchronous active-high reset
//   btn_in     raw asynchronous button levels [N_BUTTONS]
//   evt_valid  event available (registered)
//   evt_id     button index of the presented event (registered)
//   evt_ready  consumer accepts the event when high together with evt_valid
//   pending    per-button pending flags (registered)
//   drop_cnt   saturating count of dropped presses (registered)
module button_event_arbiter #(
  parameter int unsigned N_BUTTONS      = 4,
  parameter int unsigned LOCKOUT_CYCLES = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_BUTTONS-1:0]         btn_in,
  output logic                         evt_valid,
  output logic [$clog2(N_BUTTONS)-1:0] evt_id,
  input  logic                         evt_ready,
  output logic [N_BUTTONS-1:0]         pending,
  output logic [7:0]                   drop_cnt
);

  localparam int unsigned ID_W  = $clog2(N_BUTTONS);
  localparam int unsigned CNT_W = $clog2(N_BUTTONS + 1);

  // Elaboration-time parameter range checks
  if (N_BUTTONS < 2 || N_BUTTONS > 16) begin : g_bad_n
    $error("button_event_arbiter: N_BUTTONS must be 2..16");
  end
  if (LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > 65535) begin : g_bad_lockout
    $error("button_event_arbiter: LOCKOUT_CYCLES must be 1..65535");
  end

  logic [N_BUTTONS-1:0] s0_q, s1_q, s2_q;
  logic [N_BUTTONS-1:0] rise;
  logic [N_BUTTONS-1:0] qual;
  logic [N_BUTTONS-1:0] pending_q, pending_d;
  logic                 evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]      evt_id_q, evt_id_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;

  logic                 loadable;
  logic                 found;
  logic [ID_W-1:0]      sel;
  logic [N_BUTTONS-1:0] grant_vec;
  logic [N_BUTTONS-1:0] drop_vec;
  logic [CNT_W-1:0]     n_drops;
  logic [8:0]           drop_sum;

  assign rise = s1_q & ~s2_q;

`ifdef BUTTON_LOCKOUT_EN
  localparam int unsigned LCW = $clog2(LOCKOUT_CYCLES + 1);

  logic [LCW-1:0] lock_q [N_BUTTONS];
  logic [LCW-1:0] lock_d [N_BUTTONS];

  // An edge qualifies only while its counter is idle; qualifying reloads it
  always_comb begin
    for (int unsigned i = 0; i < N_BUTTONS; i++) begin
      lock_d[i] = lock_q[i];
      qual[i]   = rise[i] & (lock_q[i] == '0);
      if (qual[i]) begin
        lock_d[i] = LCW'(LOCKOUT_CYCLES);
      end else if (lock_q[i] != '0) begin
        lock_d[i] = lock_q[i] - LCW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_BUTTONS; i++) lock_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_BUTTONS; i++) lock_q[i] <= lock_d[i];
    end
  end
`else
  assign qual = rise;
`endif

  assign loadable = ~evt_valid_q | evt_ready;

  // Round-robin search: first pending bit starting at last+1, wrapping
  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] idx_w;
    idx   = 0;
    idx_w = '0;
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 1; k <= N_BUTTONS; k++) begin
      idx   = (32'(last_q) + k) % N_BUTTONS;
      idx_w = ID_W'(idx);
      if (!found && pending_q[idx_w]) begin
        found = 1'b1;
        sel   = idx_w;
      end
    end
  end

  // Grant, pending update (set wins over grant-clear), drop counting
  always_comb begin
    grant_vec   = '0;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    last_d      = last_q;
    n_drops     = '0;

    if (loadable) begin
      evt_valid_d = found;
      if (found) begin
        grant_vec[sel] = 1'b1;
        evt_id_d       = sel;
        last_d         = sel;
      end
    end

    pending_d = (pending_q & ~grant_vec) | qual;
    drop_vec  = qual & pending_q & ~grant_vec;

    for (int unsigned i = 0; i < N_BUTTONS; i++) begin
      n_drops = n_drops + CNT_W'(drop_vec[i]);
    end
    drop_sum   = {1'b0, drop_cnt_q} + 9'(n_drops);
    drop_cnt_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q        <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      pending_q   <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      last_q      <= ID_W'(N_BUTTONS - 1);
      drop_cnt_q  <= '0;
    end else begin
      s0_q        <= btn_in;
      s1_q        <= s0_q;
      s2_q        <= s1_q;
      pending_q   <= pending_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      last_q      <= last_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign pending   = pending_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench for button_event_arbiter (N_BUTTONS=4, LOCKOUT_CYCLES=8).
// Expected event ids are pushed to a queue when presses are driven and are
// popped by a monitor on every accepted handshake.
module tb_button_event_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned ID_W = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    btn_in;
  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_ready;
  logic [N-1:0]    pending;
  logic [7:0]      drop_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int          exp_q[$];

  button_event_arbiter #(
    .N_BUTTONS     (N),
    .LOCKOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .evt_valid(evt_valid),
    .evt_id   (evt_id),
    .evt_ready(evt_ready),
    .pending  (pending),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every handshake must match the oldest expected id
  always @(negedge clk) begin : monitor
    int e;
    if (!rst && evt_valid && evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got event id %0d, required no event", evt_id);
      end else begin
        e = exp_q.pop_front();
        if (evt_id !== ID_W'(e)) begin
          errors++;
          $display("FAIL sb_id: got id %0d, required %0d", evt_id, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    btn_in    = '0;
    evt_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    btn_in    = '0;
    evt_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (evt_valid !== 1'b0 || pending !== 4'h0) begin
      errors++;
      $display("FAIL reset_held: valid=%b pending=%h, required 0/0", evt_valid, pending);
    end
    rst = 1'b0;
    step();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b, required 0", evt_valid);
    end
    checks++;
    if (evt_id !== 2'd0) begin
      errors++; $display("FAIL reset_id: got %0d, required 0", evt_id);
    end
    checks++;
    if (pending !== 4'h0) begin
      errors++; $display("FAIL reset_pending: got %h, required 0", pending);
    end
    checks++;
    if (drop_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_drop: got %0d, required 0", drop_cnt);
    end
  endtask

  // Button 2 held for 20 cycles: one event, 3 clocks after first sampling edge
  task automatic test_single();
    evt_ready = 1'b1;
    btn_in    = 4'b0100;
    exp_q.push_back(2);
    repeat (3) step();
    checks++;
    if (pending !== 4'b0100 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pending: pending=%h valid=%b, required 4/0", pending, evt_valid);
    end
    step();
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd2 || pending !== 4'h0) begin
      errors++;
      $display("FAIL single_latency: valid=%b id=%0d pending=%h, required 1/2/0",
               evt_valid, evt_id, pending);
    end
    repeat (16) step();
    btn_in = '0;
    repeat (6) step();
    checks++;
    if (evt_valid !== 1'b0 || drop_cnt !== 8'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_done: valid=%b drop=%0d left=%0d, required 0/0/0",
               evt_valid, drop_cnt, exp_q.size());
    end
  endtask

  // All buttons together: ids 0..3 on consecutive cycles, then idle
  task automatic test_all_simultaneous();
    do_reset();
    btn_in = 4'hF;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== ID_W'(i)) begin
        errors++;
        $display("FAIL rr_seq: slot %0d valid=%b id=%0d, required 1/%0d", i, evt_valid, evt_id, i);
      end
    end
    step();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL rr_idle: valid=%b, required 0", evt_valid);
    end
    btn_in = '0;
    repeat (4) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rr_left: %0d events left, required 0", exp_q.size());
    end
  endtask

  // Back-pressure: presented event holds while evt_ready is low
  task automatic test_stall();
    evt_ready = 1'b0;
    btn_in    = 4'b0010;
    exp_q.push_back(1);
    repeat (3) step();
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d valid=%b id=%0d, required 1/1", c, evt_valid, evt_id);
      end
    end
    evt_ready = 1'b1;
    step();
    checks++;
    if (evt_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_accept: valid=%b left=%0d, required 0/0", evt_valid, exp_q.size());
    end
    btn_in = '0;
    repeat (12) step();
  endtask

  task automatic press3();
    btn_in[3] = 1'b1;
    repeat (2) step();
    btn_in[3] = 1'b0;
    repeat (2) step();
  endtask

`ifndef BUTTON_LOCKOUT_EN
  // Repeated presses while stalled: one presented, one pending, rest dropped
  task automatic test_drop();
    evt_ready = 1'b0;
    for (int p = 0; p < 5; p++) begin
      if (p < 2) exp_q.push_back(3);
      press3();
    end
    repeat (4) step();
    checks++;
    if (drop_cnt !== 8'd3) begin
      errors++; $display("FAIL drop_count: got %0d, required 3", drop_cnt);
    end
    checks++;
    if (pending !== 4'b1000 || evt_valid !== 1'b1 || evt_id !== 2'd3) begin
      errors++;
      $display("FAIL drop_state: pending=%h valid=%b id=%0d, required 8/1/3",
               pending, evt_valid, evt_id);
    end
    for (int p = 0; p < 260; p++) press3();
    repeat (2) step();
    checks++;
    if (drop_cnt !== 8'd255) begin
      errors++; $display("FAIL drop_saturate: got %0d, required 255", drop_cnt);
    end
    evt_ready = 1'b1;
    repeat (4) step();
    checks++;
    if (evt_valid !== 1'b0 || pending !== 4'h0 || exp_q.size() != 0 || drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL drop_drain: valid=%b pending=%h left=%0d drop=%0d, required 0/0/0/255",
               evt_valid, pending, exp_q.size(), drop_cnt);
    end
  endtask
`else
  // Lockout of 8: edge 3 cycles later ignored, edge well after window accepted
  task automatic test_lockout();
    do_reset();
    btn_in[0] = 1'b1;
    exp_q.push_back(0);
    step();
    btn_in[0] = 1'b0;
    repeat (2) step();
    btn_in[0] = 1'b1;
    repeat (8) step();
    checks++;
    if (exp_q.size() != 0 || evt_valid !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL lockout_first: left=%0d valid=%b drop=%0d, required 0/0/0",
               exp_q.size(), evt_valid, drop_cnt);
    end
    btn_in[0] = 1'b0;
    repeat (10) step();
    btn_in[0] = 1'b1;
    exp_q.push_back(0);
    repeat (6) step();
    checks++;
    if (exp_q.size() != 0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL lockout_second: left=%0d drop=%0d, required 0/0", exp_q.size(), drop_cnt);
    end
    btn_in = '0;
    repeat (12) step();
  endtask
`endif

  // Reset mid-handshake discards everything; held button gives one event
  task automatic test_reset_mid();
    evt_ready = 1'b0;
    btn_in    = 4'b0111;
    repeat (5) step();
    checks++;
    if (evt_valid !== 1'b1 || pending === 4'h0) begin
      errors++;
      $display("FAIL rstmid_pre: valid=%b pending=%h, required 1/nonzero", evt_valid, pending);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (evt_valid !== 1'b0 || evt_id !== 2'd0 || pending !== 4'h0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_async: valid=%b id=%0d pending=%h drop=%0d, required all 0",
               evt_valid, evt_id, pending, drop_cnt);
    end
    btn_in    = 4'b0010;
    evt_ready = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    exp_q.push_back(1);
    repeat (8) step();
    checks++;
    if (exp_q.size() != 0 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_held: left=%0d valid=%b, required 0/0", exp_q.size(), evt_valid);
    end
    btn_in = '0;
    repeat (3) step();
  endtask

  initial begin
    rst       = 1'b1;
    btn_in    = '0;
    evt_ready = 1'b1;
    test_reset();
    test_single();
    test_all_simultaneous();
    test_stall();
`ifndef BUTTON_LOCKOUT_EN
    test_drop();
`else
    test_lockout();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Collects rising-edge press events from `N_BUTTONS` asynchronous push-buttons and serialises them onto one event stream with a valid/ready handshake. Each input has its own 3-flop synchroniser, rising-edge detector and optional lockout (debounce) timer. Pending presses are granted round-robin to the consumer, typically the lab control FSM. Presses that cannot be queued are counted, not silently lost.

## Interface
- `N_BUTTONS`, default 4: number of button inputs, 2..16.
- `LOCKOUT_CYCLES`, default 1000: per-button ignore window after an accepted or dropped edge, 1..65535.
- `clk`  in  1  system clock, all flops on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `btn_in`  in  N_BUTTONS  raw asynchronous button levels.
- `evt_valid`  out  1  event available.
- `evt_id`  out  $clog2(N_BUTTONS)  index of the button for the presented event.
- `evt_ready`  in  1  consumer accepts the event when high together with `evt_valid`.
- `pending`  out  N_BUTTONS  registered per-button pending flags.
- `drop_cnt`  out  8  saturating count of dropped presses.

## Operation
- Synchroniser per bit: `s0<=btn_in`, `s1<=s0`, `s2<=s1`. Edge pulse `e[i] = s1[i] & ~s2[i]`.
- An edge is qualified if it is not suppressed by lockout. See Configuration.
- Qualified edge, `pending[i]==0` or being granted this cycle: set `pending[i]`. On simultaneous set and clear, set wins.
- Qualified edge, `pending[i]==1` and not being granted: drop it and increment `drop_cnt`, saturating at 255.
- Output register is loadable when `evt_valid==0`, or when `evt_valid & evt_ready`.
  - If loadable and `pending != 0`: pick the first set bit searching from `last+1` upward, wrapping modulo N_BUTTONS.
  - On the next edge: `evt_valid<=1`, `evt_id<=sel`, `pending[sel]<=0`, `last<=sel`.
  - If loadable and `pending == 0`: `evt_valid<=0`.
- While `evt_valid & ~evt_ready`: `evt_valid` and `evt_id` hold, and no new grant is made.
- Accept and re-grant happen back-to-back. A new event can be presented every cycle.
- Reset clears `s0..s2`, `pending`, `evt_valid`, `evt_id` (to 0), `drop_cnt` (to 0) and lockout counters (to 0). `last` resets to N_BUTTONS-1, so button 0 has first priority.
- A button held high through reset release produces exactly one event, because the synchroniser goes 0→1.
- Reset asserted mid-handshake discards the presented event and all pending presses.

## Timing
- `btn_in[i]` first sampled high at edge k:
  - `s1` high after k+1.
  - `pending[i]` high after k+2.
  - `evt_valid` high after k+3, if the output is loadable and `i` wins arbitration.
- Minimum latency from press to event is 3 clocks.
- `pending` is registered and reflects grants one cycle after they occur.
- Arbitration is fair: with all bits pending and `evt_ready` tied high, ids repeat 0,1,…,N-1 with no gaps.
- Lockout counter loads `LOCKOUT_CYCLES` on the qualified-edge cycle and decrements to 0. Edges are ignored while the counter is nonzero.
- Edges ignored during lockout are not counted in `drop_cnt`.

## Configuration
- `BUTTON_LOCKOUT_EN` defined:
  - Per-button lockout counters are present.
  - The counter width is $clog2(LOCKOUT_CYCLES+1).
- Not defined:
  - No counters are built.
  - Every edge pulse is qualified.
  - `LOCKOUT_CYCLES` is unused.
- The ports are identical in both builds.

## Test plan
- Reset release with all buttons low, N=4, `evt_ready=1`. Raise `btn_in[2]` for 20 cycles → one event with `evt_id=2`, 3 clocks after the first sampling edge; `drop_cnt=0`.
- All four buttons rise in the same cycle, `evt_ready=1` → ids 0,1,2,3 on consecutive cycles, then `evt_valid=0`.
- `evt_ready=0` and button 1 pressed → `evt_valid=1`, `evt_id=1` held stable for 10 cycles. Raise `evt_ready` → accepted, then `evt_valid=0`.
- Lockout build, LOCKOUT_CYCLES=8. Toggle `btn_in[0]` to produce edges 3 cycles apart → only the first produces an event; an edge ≥9 cycles later produces a second event.
- Non-lockout build, `evt_ready=0`. Press button 3 five times → one `pending[3]` event and `drop_cnt=3`. The first press is presented and the second goes pending. Repeat until saturation → `drop_cnt` holds at 255.
- Assert `rst` while `evt_valid=1` with pending bits set → all outputs 0 asynchronously. With `btn_in[1]` held high across release → exactly one event with id 1.
